tdp_ram_be: RTL and testbench

Parametrised true dual-port synchronous RAM. It is the next generation of the team's single-port RAM and adds:
- two independent read/write ports (A, B) on one clock;
- per-byte write enables;
- a selectable write mode per port;
- a configurable read latency with data-valid strobes;
- a hardware memory-clear sequencer.

It serves as the shared scratch/buffer memory between a producer and a consumer datapath.

---
 rtl/ram_pkg.sv | 20 ++
 rtl/ram_rd_pipe.sv | 75 +++++++
 rtl/tdp_ram_be.sv | 150 +++++++++++++++
 tb/tb_tdp_ram_be.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types for the true dual-port byte-enable RAM: write modes, clear FSM
// states and the byte-lane count helper.
package ram_pkg;

  typedef enum logic [1:0] {
    WM_READ_FIRST  = 2'd0,
    WM_WRITE_FIRST = 2'd1,
    WM_NO_CHANGE   = 2'd2
  } wmode_t;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_t;

  function automatic int calc_nbe(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Per-port read output stage: one or two register stages for dout/dvalid,
// selecting old or merged word according to the port write mode.
module ram_rd_pipe
  import ram_pkg::*;
#(
  parameter int     DATA_WIDTH = 32,
  parameter int     RD_LATENCY = 1,
  parameter wmode_t MODE       = WM_READ_FIRST
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  acc,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] old_word,
  input  logic [DATA_WIDTH-1:0] new_word,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dvalid
);

  logic [DATA_WIDTH-1:0] dout1_d, dout1_q;
  logic                  dvalid1_d, dvalid1_q;

  // First stage: NO_CHANGE writes leave dout untouched and raise no strobe.
  always_comb begin
    dout1_d   = dout1_q;
    dvalid1_d = 1'b0;
    if (acc && !(we && (MODE == WM_NO_CHANGE))) begin
      dvalid1_d = 1'b1;
      if (we && (MODE == WM_WRITE_FIRST)) begin
        dout1_d = new_word;
      end else begin
        dout1_d = old_word;
      end
    end else begin
      dout1_d   = dout1_q;
      dvalid1_d = 1'b0;
    end
  end

  // First output register stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout1_q   <= '0;
      dvalid1_q <= 1'b0;
    end else begin
      dout1_q   <= dout1_d;
      dvalid1_q <= dvalid1_d;
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] dout2_q;
      logic                  dvalid2_q;

      // Extra stage; it copies stage one, so a held value stays held.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          dout2_q   <= '0;
          dvalid2_q <= 1'b0;
        end else begin
          dout2_q   <= dout1_q;
          dvalid2_q <= dvalid1_q;
        end
      end

      assign dout   = dout2_q;
      assign dvalid = dvalid2_q;
    end else begin : g_lat1
      assign dout   = dout1_q;
      assign dvalid = dvalid1_q;
    end
  endgenerate

endmodule

// File: rtl/tdp_ram_be.sv
// True dual-port byte-enable RAM with selectable write modes, configurable read
// latency, write/write collision flag and a full-memory clear sequencer.
module tdp_ram_be
  import ram_pkg::*;
#(
  parameter int     DATA_WIDTH = 32,
  parameter int     ADDR_WIDTH = 8,
  parameter int     BYTE_W     = 8,
  parameter int     RD_LATENCY = 1,
  parameter wmode_t A_MODE     = WM_READ_FIRST,
  parameter wmode_t B_MODE     = WM_READ_FIRST,
  localparam int    NBE        = calc_nbe(DATA_WIDTH, BYTE_W),
  localparam int    DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_en,
  input  logic                  a_we,
  input  logic [NBE-1:0]        a_be,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic [DATA_WIDTH-1:0] a_dout,
  output logic                  a_dvalid,
  input  logic                  b_en,
  input  logic                  b_we,
  input  logic [NBE-1:0]        b_be,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_din,
  output logic [DATA_WIDTH-1:0] b_dout,
  output logic                  b_dvalid,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  collision
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  clr_state_t            state_d, state_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_d, clr_cnt_q;
  logic                  clr_busy_d, clr_busy_q;
  logic                  collision_d, collision_q;

  logic                  a_acc, b_acc, a_wr, b_wr;
  logic [DATA_WIDTH-1:0] a_mask, b_mask, a_old, b_old, a_new, b_new;

  // Port qualification, lane masks and merged write words.
  always_comb begin
    a_mask = '0;
    b_mask = '0;
    for (int i = 0; i < NBE; i++) begin
      a_mask[i*BYTE_W +: BYTE_W] = {BYTE_W{a_be[i]}};
      b_mask[i*BYTE_W +: BYTE_W] = {BYTE_W{b_be[i]}};
    end
    a_acc       = a_en && !clr_busy_q;
    b_acc       = b_en && !clr_busy_q;
    a_wr        = a_acc && a_we;
    b_wr        = b_acc && b_we;
    a_old       = mem[a_addr];
    b_old       = mem[b_addr];
    a_new       = (a_old & ~a_mask) | (a_din & a_mask);
    b_new       = (b_old & ~b_mask) | (b_din & b_mask);
    collision_d = a_wr && b_wr && (a_addr == b_addr);
  end

  // Array writes: port A lanes are written after B so A wins on overlap.
  always_ff @(posedge clk) begin
    if (clr_busy_q) begin
      mem[clr_cnt_q] <= '0;
    end else begin
      for (int i = 0; i < NBE; i++) begin
        if (b_wr && b_be[i]) begin
          mem[b_addr][i*BYTE_W +: BYTE_W] <= b_din[i*BYTE_W +: BYTE_W];
        end
        if (a_wr && a_be[i]) begin
          mem[a_addr][i*BYTE_W +: BYTE_W] <= a_din[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Clear FSM state, counter and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= CLR_IDLE;
      clr_cnt_q   <= '0;
      clr_busy_q  <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      clr_busy_q  <= clr_busy_d;
      collision_q <= collision_d;
    end
  end

  // Clear FSM next state; the run ends after the all-ones address is cleared.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLR_IDLE: state_d = clr_start ? CLR_RUN : CLR_IDLE;
      CLR_RUN:  state_d = (&clr_cnt_q) ? CLR_IDLE : CLR_RUN;
      default:  state_d = CLR_IDLE;
    endcase
  end

  // Clear FSM outputs.
  always_comb begin
    clr_cnt_d  = clr_cnt_q;
    clr_busy_d = (state_d == CLR_RUN);
    case (state_q)
      CLR_IDLE: clr_cnt_d = '0;
      CLR_RUN:  clr_cnt_d = clr_cnt_q + 1'b1;
      default:  clr_cnt_d = '0;
    endcase
  end

  assign clr_busy  = clr_busy_q;
  assign collision = collision_q;

  ram_rd_pipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .RD_LATENCY(RD_LATENCY),
    .MODE      (A_MODE)
  ) u_pipe_a (
    .clk     (clk),
    .reset   (reset),
    .acc     (a_acc),
    .we      (a_we),
    .old_word(a_old),
    .new_word(a_new),
    .dout    (a_dout),
    .dvalid  (a_dvalid)
  );

  ram_rd_pipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .RD_LATENCY(RD_LATENCY),
    .MODE      (B_MODE)
  ) u_pipe_b (
    .clk     (clk),
    .reset   (reset),
    .acc     (b_acc),
    .we      (b_we),
    .old_word(b_old),
    .new_word(b_new),
    .dout    (b_dout),
    .dvalid  (b_dvalid)
  );

endmodule

// File: tb/tb_tdp_ram_be.sv
// Bench for tdp_ram_be: a default instance (latency 1, READ_FIRST) and a second
// one (latency 2, A WRITE_FIRST, B NO_CHANGE) driven by the same stimulus.
module tb_tdp_ram_be;
  import ram_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_en, a_we, b_en, b_we, clr_start;
  logic [3:0]  a_be, b_be;
  logic [7:0]  a_addr, b_addr;
  logic [31:0] a_din, b_din;

  logic [31:0] a_dout, b_dout, a_dout2, b_dout2;
  logic        a_dvalid, b_dvalid, clr_busy, collision;
  logic        a_dvalid2, b_dvalid2, clr_busy2, collision2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tdp_ram_be u_dut (
    .clk(clk), .reset(reset),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout), .a_dvalid(a_dvalid),
    .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
    .b_dout(b_dout), .b_dvalid(b_dvalid),
    .clr_start(clr_start), .clr_busy(clr_busy), .collision(collision)
  );

  tdp_ram_be #(
    .RD_LATENCY(2), .A_MODE(WM_WRITE_FIRST), .B_MODE(WM_NO_CHANGE)
  ) u_dut2 (
    .clk(clk), .reset(reset),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout2), .a_dvalid(a_dvalid2),
    .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
    .b_dout(b_dout2), .b_dvalid(b_dvalid2),
    .clr_start(clr_start), .clr_busy(clr_busy2), .collision(collision2)
  );

  typedef struct {
    logic        a_en, a_we;
    logic [3:0]  a_be;
    logic [7:0]  a_addr;
    logic [31:0] a_din;
    logic        b_en, b_we;
    logic [3:0]  b_be;
    logic [7:0]  b_addr;
    logic [31:0] b_din;
    logic [31:0] ea_dout;
    logic        ea_dv;
    logic [31:0] eb_dout;
    logic        eb_dv;
    logic        ecol;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    a_en = 1'b0; a_we = 1'b0; a_be = 4'h0; a_addr = 8'h00; a_din = 32'h0;
    b_en = 1'b0; b_we = 1'b0; b_be = 4'h0; b_addr = 8'h00; b_din = 32'h0;
    clr_start = 1'b0;
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [7:0] lo;
    lo = i[7:0];
    return {8'hA5, lo, ~lo, 8'h3C};
  endfunction

  task automatic fill_all();
    for (int i = 0; i < 256; i++) begin
      a_en = 1'b1; a_we = 1'b1; a_be = 4'hF; a_addr = i[7:0]; a_din = pat(i);
      step();
    end
    idle();
  endtask

  task automatic check_all(input int zero_upto);
    for (int i = 0; i < 256; i++) begin
      a_en = 1'b1; a_we = 1'b0; a_be = 4'h0; a_addr = i[7:0];
      step();
      chk($sformatf("word_%0d", i), a_dout, (i < zero_upto) ? 32'h0 : pat(i));
    end
    idle();
  endtask

  initial begin
    int   busy_cnt;
    logic seen_dv;

    // ea/eb: expected douts of the latency-1 READ_FIRST instance
    vecs[0]  = '{1,1,4'hF,8'd5,  32'hDEADBEEF, 0,0,4'h0,8'd0,  32'h0,
                 32'h00000000,1, 32'h00000000,0, 0};
    vecs[1]  = '{0,0,4'h0,8'd0,  32'h0,        1,0,4'h0,8'd5,  32'h0,
                 32'h00000000,0, 32'hDEADBEEF,1, 0};
    vecs[2]  = '{1,1,4'h5,8'd5,  32'h11223344, 0,0,4'h0,8'd0,  32'h0,
                 32'hDEADBEEF,1, 32'hDEADBEEF,0, 0};
    vecs[3]  = '{1,0,4'h0,8'd5,  32'h0,        1,0,4'h0,8'd9,  32'h0,
                 32'hDE22BE44,1, 32'h00000000,1, 0};
    vecs[4]  = '{1,1,4'hF,8'd9,  32'hCAFEF00D, 1,0,4'h0,8'd9,  32'h0,
                 32'h00000000,1, 32'h00000000,1, 0};
    vecs[5]  = '{1,1,4'h0,8'd7,  32'hFFFFFFFF, 1,0,4'h0,8'd9,  32'h0,
                 32'h00000000,1, 32'hCAFEF00D,1, 0};
    vecs[6]  = '{1,0,4'h0,8'd7,  32'h0,        0,0,4'h0,8'd0,  32'h0,
                 32'h00000000,1, 32'hCAFEF00D,0, 0};
    vecs[7]  = '{1,1,4'hF,8'd3,  32'hAAAAAAAA, 1,1,4'hF,8'd3,  32'h55555555,
                 32'h00000000,1, 32'h00000000,1, 1};
    vecs[8]  = '{1,0,4'h0,8'd3,  32'h0,        0,0,4'h0,8'd0,  32'h0,
                 32'hAAAAAAAA,1, 32'h00000000,0, 0};
    vecs[9]  = '{1,1,4'h3,8'd3,  32'hAAAAAAAA, 1,1,4'hF,8'd3,  32'h55555555,
                 32'hAAAAAAAA,1, 32'hAAAAAAAA,1, 1};
    vecs[10] = '{0,0,4'h0,8'd0,  32'h0,        1,0,4'h0,8'd3,  32'h0,
                 32'hAAAAAAAA,0, 32'h5555AAAA,1, 0};
    vecs[11] = '{1,1,4'hF,8'd255,32'h12345678, 1,1,4'hF,8'd0,  32'h87654321,
                 32'h00000000,1, 32'h00000000,1, 0};
    vecs[12] = '{1,0,4'h0,8'd0,  32'h0,        1,0,4'h0,8'd255,32'h0,
                 32'h87654321,1, 32'h12345678,1, 0};
    vecs[13] = '{0,0,4'h0,8'd0,  32'h0,        0,0,4'h0,8'd0,  32'h0,
                 32'h87654321,0, 32'h12345678,0, 0};

    idle();
    reset = 1'b1;
    repeat (3) step();
    chk("rst_a_dout", a_dout, 32'h0);
    chk("rst_a_dvalid", {31'h0, a_dvalid}, 32'h0);
    chk("rst_b_dout", b_dout, 32'h0);
    chk("rst_b_dvalid", {31'h0, b_dvalid}, 32'h0);
    chk("rst_collision", {31'h0, collision}, 32'h0);
    chk("rst_clr_busy", {31'h0, clr_busy}, 32'h0);
    chk("rst_dut2_a_dout", a_dout2, 32'h0);
    reset = 1'b0;
    step();

    // Start from a known all-zero memory.
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    busy_cnt = 0;
    while (clr_busy && busy_cnt < 400) begin
      step();
      busy_cnt++;
    end
    chk("init_clear_done", {31'h0, clr_busy}, 32'h0);

    for (int v = 0; v < 14; v++) begin
      a_en = vecs[v].a_en; a_we = vecs[v].a_we; a_be = vecs[v].a_be;
      a_addr = vecs[v].a_addr; a_din = vecs[v].a_din;
      b_en = vecs[v].b_en; b_we = vecs[v].b_we; b_be = vecs[v].b_be;
      b_addr = vecs[v].b_addr; b_din = vecs[v].b_din;
      step();
      chk($sformatf("v%0d_a_dout", v), a_dout, vecs[v].ea_dout);
      chk($sformatf("v%0d_a_dvalid", v), {31'h0, a_dvalid}, {31'h0, vecs[v].ea_dv});
      chk($sformatf("v%0d_b_dout", v), b_dout, vecs[v].eb_dout);
      chk($sformatf("v%0d_b_dvalid", v), {31'h0, b_dvalid}, {31'h0, vecs[v].eb_dv});
      chk($sformatf("v%0d_collision", v), {31'h0, collision}, {31'h0, vecs[v].ecol});
    end
    idle();

    // Write modes on zero words: A writes 20, B writes 21 in the same cycle.
    a_en = 1'b1; a_we = 1'b1; a_be = 4'hF; a_addr = 8'd20; a_din = 32'hCAFEF00D;
    b_en = 1'b1; b_we = 1'b1; b_be = 4'hF; b_addr = 8'd21; b_din = 32'h0BADF00D;
    step();
    idle();
    chk("rf_a_dout", a_dout, 32'h0);
    chk("rf_a_dvalid", {31'h0, a_dvalid}, 32'h1);
    chk("rf_b_dout", b_dout, 32'h0);
    chk("lat2_a_dvalid_early", {31'h0, a_dvalid2}, 32'h0);
    chk("lat2_a_dout_early", a_dout2, 32'h87654321);
    step();
    chk("wf_a_dout", a_dout2, 32'hCAFEF00D);
    chk("wf_a_dvalid", {31'h0, a_dvalid2}, 32'h1);
    chk("nc_b_dvalid", {31'h0, b_dvalid2}, 32'h0);
    chk("nc_b_dout_hold", b_dout2, 32'h12345678);
    step();
    chk("wf_a_dvalid_pulse", {31'h0, a_dvalid2}, 32'h0);
    b_en = 1'b1; b_we = 1'b0; b_addr = 8'd21;
    step();
    idle();
    step();
    chk("nc_b_readback", b_dout2, 32'h0BADF00D);
    chk("nc_b_readback_dv", {31'h0, b_dvalid2}, 32'h1);

    // Full clear: access in the start cycle is accepted, later ones ignored.
    fill_all();
    clr_start = 1'b1;
    a_en = 1'b1; a_we = 1'b0; a_addr = 8'd1;
    step();
    clr_start = 1'b0;
    chk("clr_start_cycle_read", a_dout, pat(1));
    chk("clr_start_cycle_dv", {31'h0, a_dvalid}, 32'h1);
    busy_cnt = clr_busy ? 1 : 0;
    seen_dv = 1'b0;
    b_en = 1'b1; b_we = 1'b1; b_be = 4'hF; b_addr = 8'd2; b_din = 32'hFFFFFFFF;
    for (int k = 0; k < 400; k++) begin
      clr_start = (k == 50);
      step();
      if (!clr_busy) break;
      busy_cnt++;
      seen_dv = seen_dv | a_dvalid | b_dvalid;
    end
    idle();
    chk("clr_busy_cycles", busy_cnt, 32'd256);
    chk("clr_ignored_dvalid", {31'h0, seen_dv}, 32'h0);
    check_all(256);

    // Reset after 100 cleared words.
    fill_all();
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    repeat (100) step();
    reset = 1'b1;
    #1;
    chk("midclr_busy", {31'h0, clr_busy}, 32'h0);
    chk("midclr_busy2", {31'h0, clr_busy2}, 32'h0);
    step();
    chk("midclr_a_dout", a_dout, 32'h0);
    reset = 1'b0;
    step();
    check_all(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
